// File: rtl/usb_boot_sequencer_if.sv
// Board-side signal bundle of the USB boot sequencer.
//   clk_ready     : PLL lock, asynchronous to the 48 MHz clock
//   btn_raw       : raw reset button, active-high, bouncy, asynchronous
//   boot_req      : boot request from usbasp_bootloader, clock-synchronous
//   core_reset    : active-high reset to usbasp_bootloader
//   usb_force_se0 : 1 = drive USB D+/D- low (SE0)
//   reconfig_n    : active-low FPGA reconfiguration request
//   state_dbg     : FSM state code for LEDs
// modport master is taken by the sequencer; modport slave by the board/bench side.
interface usb_boot_sequencer_if;
    logic       clk_ready;
    logic       btn_raw;
    logic       boot_req;
    logic       core_reset;
    logic       usb_force_se0;
    logic       reconfig_n;
    logic [2:0] state_dbg;

    modport master (
        input  clk_ready, btn_raw, boot_req,
        output core_reset, usb_force_se0, reconfig_n, state_dbg
    );

    modport slave (
        output clk_ready, btn_raw, boot_req,
        input  core_reset, usb_force_se0, reconfig_n, state_dbg
    );
endinterface

// File: rtl/usb_boot_sequencer.sv
// Reset/reboot controller in front of usbasp_bootloader.
// Waits for PLL lock and a released (debounced) reset button, holds the USB lines in SE0
// long enough for the host to notice a disconnect, then releases the core reset. A rising
// edge on the bootloader's boot request starts a grace period, after which the FPGA
// reconfiguration request is driven low and held until block reset.
// Ports:
//   clk_48mhz : 48 MHz system clock
//   reset     : synchronous, active-high block reset
//   bus       : usb_boot_sequencer_if.master (lock, button, boot request in;
//               core_reset, usb_force_se0, reconfig_n, state_dbg out)
module usb_boot_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 480000,
    parameter int SE0_CYCLES        = 960000,
    parameter int BOOT_DELAY_CYCLES = 48000
) (
    input  logic                        clk_48mhz,
    input  logic                        reset,
    usb_boot_sequencer_if.master        bus
);

    localparam int DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_MAX = (SE0_CYCLES > BOOT_DELAY_CYCLES) ? SE0_CYCLES : BOOT_DELAY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(SE0_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SE0       = 3'd1,
        RUN       = 3'd2,
        BOOT_WAIT = 3'd3,
        REBOOT    = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic               lock_s1, lock_s;
    logic               btn_s1, btn_s;
    logic               btn_db;
    logic               boot_req_q;
    logic               core_reset_r, se0_r, reconfig_n_r;
    logic [2:0]         state_dbg_r;

    logic abort;
    logic boot_rise;

    assign abort     = ~lock_s | btn_db;
    assign boot_rise = bus.boot_req & ~boot_req_q;

    assign bus.core_reset    = core_reset_r;
    assign bus.usb_force_se0 = se0_r;
    assign bus.reconfig_n    = reconfig_n_r;
    assign bus.state_dbg     = state_dbg_r;

    // Input conditioning: 2-flop synchronizers, button debounce, boot_req edge history.
    // btn_db only follows btn_s after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            lock_s1    <= 1'b0;
            lock_s     <= 1'b0;
            btn_s1     <= 1'b0;
            btn_s      <= 1'b0;
            btn_db     <= 1'b0;
            deb_cnt    <= '0;
            boot_req_q <= 1'b0;
        end else begin
            lock_s1    <= bus.clk_ready;
            lock_s     <= lock_s1;
            btn_s1     <= bus.btn_raw;
            btn_s      <= btn_s1;
            boot_req_q <= bus.boot_req;
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Sequencer FSM. Outputs decode the current (pre-update) state, so they trail the
    // state register by one cycle. cnt holds at its last value on expiry.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            core_reset_r <= 1'b1;
            se0_r        <= 1'b1;
            reconfig_n_r <= 1'b1;
            state_dbg_r  <= 3'd0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!abort) begin
                        state <= SE0;
                        cnt   <= '0;
                    end
                end
                SE0: begin
                    if (abort)                state <= WAIT_LOCK;
                    else if (cnt == SE0_LAST) state <= RUN;
                    else                      cnt   <= cnt + 1'b1;
                end
                RUN: begin
                    if (abort) begin
                        state <= WAIT_LOCK;
                    end else if (boot_rise) begin
                        state <= BOOT_WAIT;
                        cnt   <= '0;
                    end
                end
                BOOT_WAIT: begin
                    if (abort)                 state <= WAIT_LOCK;
                    else if (cnt == BOOT_LAST) state <= REBOOT;
                    else                       cnt   <= cnt + 1'b1;
                end
                REBOOT: begin
                    // terminal until block reset
                end
                default: state <= WAIT_LOCK;
            endcase

            state_dbg_r <= state;
            case (state)
                RUN, BOOT_WAIT: begin
                    core_reset_r <= 1'b0;
                    se0_r        <= 1'b0;
                    reconfig_n_r <= 1'b1;
                end
                REBOOT: begin
                    core_reset_r <= 1'b1;
                    se0_r        <= 1'b1;
                    reconfig_n_r <= 1'b0;
                end
                default: begin
                    core_reset_r <= 1'b1;
                    se0_r        <= 1'b1;
                    reconfig_n_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_boot_sequencer.sv
// Self-checking bench for usb_boot_sequencer (DEBOUNCE=4, SE0=8, BOOT_DELAY=5).
// Each scenario task queues the output word {state_dbg, core_reset, usb_force_se0,
// reconfig_n} expected after a given clock edge, drives its stimulus cycle by cycle and
// compares queued entries as their edge is reached.
module tb_usb_boot_sequencer;

    logic clk = 1'b0;
    logic reset;

    usb_boot_sequencer_if bus();

    usb_boot_sequencer #(
        .DEBOUNCE_CYCLES  (4),
        .SE0_CYCLES       (8),
        .BOOT_DELAY_CYCLES(5)
    ) dut (
        .clk_48mhz(clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [5:0] obs;
    assign obs = {bus.state_dbg, bus.core_reset, bus.usb_force_se0, bus.reconfig_n};

    function automatic void push(int at, logic [2:0] st, logic cr, logic se, logic rn, string name);
        exp_t e;
        e.at   = at;
        e.exp  = {st, cr, se, rn};
        e.name = name;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int base;
        exp_t e;
        base = cyc;
        push(base + 2, 3'd0, 1, 1, 1, "reset_hold");
        push(base + 6, 3'd0, 1, 1, 1, "reset_no_lock");
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                reset = 1'b1;
                bus.clk_ready = 1'b0;
                bus.btn_raw = 1'b0;
                bus.boot_req = 1'b0;
            end
            if (n == 3) reset = 1'b0;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_power_up();
        int base;
        exp_t e;
        base = cyc;
        push(base + 3,  3'd0, 1, 1, 1, "pu_wait_lock");
        push(base + 4,  3'd1, 1, 1, 1, "pu_se0");
        push(base + 11, 3'd1, 1, 1, 1, "pu_se0_last");
        push(base + 12, 3'd2, 0, 0, 1, "pu_run");
        push(base + 16, 3'd2, 0, 0, 1, "pu_run_hold");
        for (int n = 0; n < 16; n++) begin
            if (n == 0) bus.clk_ready = 1'b1;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int base;
        exp_t e;
        base = cyc;
        push(base + 4,  3'd2, 0, 0, 1, "bounce_ignored_a");
        push(base + 8,  3'd2, 0, 0, 1, "bounce_ignored_b");
        push(base + 12, 3'd2, 0, 0, 1, "bounce_ignored_c");
        push(base + 14, 3'd2, 0, 0, 1, "bounce_ignored_d");
        push(base + 23, 3'd2, 0, 0, 1, "press_lag");
        push(base + 24, 3'd0, 1, 1, 1, "press_abort");
        push(base + 30, 3'd1, 1, 1, 1, "release_se0");
        push(base + 37, 3'd1, 1, 1, 1, "release_se0_last");
        push(base + 38, 3'd2, 0, 0, 1, "release_run");
        for (int n = 0; n < 40; n++) begin
            if (n == 0)  bus.btn_raw = 1'b1;
            if (n == 3)  bus.btn_raw = 1'b0;
            if (n == 5)  bus.btn_raw = 1'b1;
            if (n == 8)  bus.btn_raw = 1'b0;
            if (n == 16) bus.btn_raw = 1'b1;
            if (n == 22) bus.btn_raw = 1'b0;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        int base;
        exp_t e;
        base = cyc;
        push(base + 1,  3'd0, 1, 1, 1, "ll_reset");
        push(base + 12, 3'd1, 1, 1, 1, "ll_se0_lag");
        push(base + 13, 3'd0, 1, 1, 1, "ll_abort");
        push(base + 17, 3'd0, 1, 1, 1, "relock_wait");
        push(base + 18, 3'd1, 1, 1, 1, "relock_se0");
        push(base + 25, 3'd1, 1, 1, 1, "relock_full_se0");
        push(base + 26, 3'd2, 0, 0, 1, "relock_run");
        for (int n = 0; n < 26; n++) begin
            if (n == 0)  reset = 1'b1;
            if (n == 1)  reset = 1'b0;
            if (n == 9)  bus.clk_ready = 1'b0;
            if (n == 14) bus.clk_ready = 1'b1;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_reboot();
        int base;
        exp_t e;
        base = cyc;
        push(base + 1,  3'd2, 0, 0, 1, "rb_lag");
        push(base + 2,  3'd3, 0, 0, 1, "rb_boot_wait");
        push(base + 6,  3'd3, 0, 0, 1, "rb_wait_last");
        push(base + 7,  3'd4, 1, 1, 0, "rb_reboot");
        push(base + 12, 3'd4, 1, 1, 0, "rb_terminal_a");
        push(base + 17, 3'd4, 1, 1, 0, "rb_terminal_b");
        push(base + 22, 3'd4, 1, 1, 0, "rb_terminal_c");
        for (int n = 0; n < 23; n++) begin
            if (n == 0) bus.boot_req = 1'b1;
            if (n == 1) bus.boot_req = 1'b0;
            if (n == 8) begin
                bus.btn_raw = 1'b1;
                bus.clk_ready = 1'b0;
            end
            if (n == 10) bus.boot_req = 1'b1;
            if (n == 11) bus.boot_req = 1'b0;
            if (n == 16) bus.btn_raw = 1'b0;
            if (n == 18) bus.clk_ready = 1'b1;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_in_reboot();
        int base;
        exp_t e;
        base = cyc;
        push(base + 1,  3'd0, 1, 1, 1, "rst_reboot");
        push(base + 2,  3'd0, 1, 1, 1, "rst_reboot_hold");
        push(base + 13, 3'd2, 0, 0, 1, "rst_reboot_rerun");
        for (int n = 0; n < 14; n++) begin
            if (n == 0) reset = 1'b1;
            if (n == 1) reset = 1'b0;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_cancel_level();
        int base;
        exp_t e;
        base = cyc;
        push(base + 15, 3'd2, 0, 0, 1, "lvl_run");
        push(base + 22, 3'd2, 0, 0, 1, "lvl_no_reboot");
        push(base + 29, 3'd3, 0, 0, 1, "cancel_boot_wait");
        push(base + 32, 3'd3, 0, 0, 1, "cancel_lag");
        push(base + 33, 3'd0, 1, 1, 1, "cancel_abort");
        push(base + 37, 3'd0, 1, 1, 1, "cancel_no_reboot");
        push(base + 47, 3'd2, 0, 0, 1, "cancel_rerun");
        for (int n = 0; n < 48; n++) begin
            if (n == 0) begin
                reset = 1'b1;
                bus.clk_ready = 1'b0;
                bus.boot_req = 1'b1;
            end
            if (n == 1)  reset = 1'b0;
            if (n == 3)  bus.clk_ready = 1'b1;
            if (n == 23) bus.boot_req = 1'b0;
            if (n == 25) bus.btn_raw = 1'b1;
            if (n == 27) bus.boot_req = 1'b1;
            if (n == 28) bus.boot_req = 1'b0;
            if (n == 31) bus.btn_raw = 1'b0;
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: {st,cr,se0,rn} got %b required %b", e.name, cyc, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.clk_ready = 1'b0;
        bus.btn_raw = 1'b0;
        bus.boot_req = 1'b0;
        test_reset();
        test_power_up();
        test_bounce();
        test_lock_loss();
        test_reboot();
        test_reset_in_reboot();
        test_cancel_level();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending got %0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
